// File: rtl/hsv_core_issue_pkg.sv
// hsv_core_issue_pkg
// Shared types and constants for the issue stage: execution unit indices,
// the decoded instruction beat (issue_data_t), the busy scoreboard vector
// and the registered operand pair.
// Optional feature macro used by the files importing this package:
//   HSV_CORE_ISSUE_WB_BYPASS_EN
package hsv_core_issue_pkg;

  // Execution unit lane indices (bit positions in exec_select / unit_valid_o)
  localparam int UNIT_ALU        = 0;
  localparam int UNIT_FOO        = 1;
  localparam int UNIT_MEM        = 2;
  localparam int UNIT_BRANCH     = 3;
  localparam int UNIT_CTRLSTATUS = 4;

  typedef logic [4:0] reg_addr_t;

  // One busy bit per architectural register; x0 has no storage at all
  typedef logic [31:1] scoreboard_t;

  // Declared MSB first so that alu lands on bit 0 of the packed vector
  typedef struct packed {
    logic ctrlstatus;
    logic branch;
    logic mem;
    logic foo;
    logic alu;
  } exec_select_t;

  typedef struct packed {
    logic [31:0] pc;
    reg_addr_t   rs1_addr;
    reg_addr_t   rs2_addr;
    reg_addr_t   rd_addr;
  } issue_common_t;

  typedef struct packed {
    logic       illegal;
    logic [3:0] op;
  } alu_data_t;

  typedef struct packed {
    issue_common_t common;
    exec_select_t  exec_select;
    alu_data_t     alu_data;
    logic [31:0]   imm;
  } issue_data_t;

  typedef struct packed {
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
  } operand_pair_t;

  // x0 always reads as zero regardless of what the register file returns
  function automatic logic [31:0] zero_x0(reg_addr_t addr, logic [31:0] data);
    return (addr == '0) ? '0 : data;
  endfunction

endpackage

// File: rtl/hsv_core_issue_if.sv
// hsv_core_issue_if
// Groups the decode-side beat handshake and the dispatch-side unit bus of
// the issue stage.
//   valid_i / ready_o / issue_data      : beat from the decode skid buffer
//   unit_valid_o / unit_ready_i         : one-hot dispatch handshake
//   dispatch_data / rs1_value/rs2_value : registered payload and operands
// Modports: slave = issue stage, master = decode/execution environment.
interface hsv_core_issue_if #(
  parameter int NUM_UNITS = 5
);
  import hsv_core_issue_pkg::*;

  logic                 valid_i;
  logic                 ready_o;
  issue_data_t          issue_data;
  logic [NUM_UNITS-1:0] unit_valid_o;
  logic [NUM_UNITS-1:0] unit_ready_i;
  issue_data_t          dispatch_data;
  logic [31:0]          rs1_value;
  logic [31:0]          rs2_value;

  modport master (
    output valid_i, issue_data, unit_ready_i,
    input  ready_o, unit_valid_o, dispatch_data, rs1_value, rs2_value
  );

  modport slave (
    input  valid_i, issue_data, unit_ready_i,
    output ready_o, unit_valid_o, dispatch_data, rs1_value, rs2_value
  );

endinterface

// File: rtl/hsv_core_issue_scoreboard.sv
// hsv_core_issue_scoreboard
// Per-register busy bits for RAW/WAW hazard detection.
// Ports:
//   clk_core, rst_core_n  : clock, synchronous active-low reset
//   flush                 : clears every busy bit
//   set_en, set_rd        : mark a destination busy (accepted instruction)
//   wb_valid, wb_rd       : writeback clears the destination
//   rs1/rs2/rd_addr       : lookup addresses
//   rs1/rs2/rd_busy       : combinational busy lookups (x0 never busy)
// With HSV_CORE_ISSUE_WB_BYPASS_EN defined, a register being written back
// this cycle already reports not busy.
module hsv_core_issue_scoreboard
  import hsv_core_issue_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic      clk_core,
  input  logic      rst_core_n,
  input  logic      flush,
  input  logic      set_en,
  input  reg_addr_t set_rd,
  input  logic      wb_valid,
  input  reg_addr_t wb_rd,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  input  reg_addr_t rd_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      rd_busy
);

  scoreboard_t busy_q;
  scoreboard_t busy_d;
  logic [31:0] busy_view;

  // Next busy state: writeback clears first, then a new destination sets,
  // so set wins when both hit the same register.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wb_valid && (wb_rd == 5'(i))) busy_d[i] = 1'b0;
      if (set_en && (set_rd == 5'(i)))  busy_d[i] = 1'b1;
    end
  end

  // Reset and flush both empty the scoreboard; flush beats any update.
  always_ff @(posedge clk_core) begin
    if (!rst_core_n || flush) busy_q <= '0;
    else                      busy_q <= busy_d;
  end

  // Lookup view with bit 0 tied low; optionally hides the register being
  // written back this cycle so a waiting consumer wakes up immediately.
  always_comb begin
    busy_view = {busy_q, 1'b0};
`ifdef HSV_CORE_ISSUE_WB_BYPASS_EN
    if (wb_valid) busy_view[wb_rd] = 1'b0;
`endif
  end

  assign rs1_busy = busy_view[rs1_addr];
  assign rs2_busy = busy_view[rs2_addr];
  assign rd_busy  = busy_view[rd_addr];

endmodule

// File: rtl/hsv_core_issue.sv
// hsv_core_issue
// Issue stage between decode and the execution units. Reads operands from
// the register file, stalls on busy sources/destination, and dispatches each
// instruction to exactly one unit through a single registered output entry.
// Ports:
//   clk_core, rst_core_n      : clock, synchronous active-low reset
//   flush_req / flush_ack     : pipeline flush, ack registered one cycle later
//   issue_bus (slave)         : decode beat in, one-hot unit dispatch out
//   rf_rs1/rs2_addr, _data    : combinational register file read ports
//   wb_valid, wb_rd, wb_data  : writeback from commit
// Optional macro HSV_CORE_ISSUE_WB_BYPASS_EN: writeback data bypasses into the
// operands and the written register is not considered busy that cycle.
module hsv_core_issue
  import hsv_core_issue_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int NUM_UNITS = 5
) (
  input  logic              clk_core,
  input  logic              rst_core_n,
  input  logic              flush_req,
  output logic              flush_ack,
  hsv_core_issue_if.slave   issue_bus,
  output reg_addr_t         rf_rs1_addr,
  output reg_addr_t         rf_rs2_addr,
  input  logic [31:0]       rf_rs1_data,
  input  logic [31:0]       rf_rs2_data,
  input  logic              wb_valid,
  input  reg_addr_t         wb_rd,
  input  logic [31:0]       wb_data
);

  issue_data_t          in_data;
  operand_pair_t        in_ops;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic                 rd_busy;
  logic                 hazard;
  logic                 drain;
  logic                 accept;
  logic                 out_valid;
  logic [NUM_UNITS-1:0] out_sel;
  issue_data_t          out_data;
  operand_pair_t        out_ops;

  assign in_data     = issue_bus.issue_data;
  assign rf_rs1_addr = in_data.common.rs1_addr;
  assign rf_rs2_addr = in_data.common.rs2_addr;

  hsv_core_issue_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .flush      (flush_req),
    .set_en     (accept),
    .set_rd     (in_data.common.rd_addr),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .rs1_addr   (in_data.common.rs1_addr),
    .rs2_addr   (in_data.common.rs2_addr),
    .rd_addr    (in_data.common.rd_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rd_busy    (rd_busy)
  );

  // The output entry frees up in the same cycle it drains, which is what
  // allows back-to-back dispatch without a bubble.
  assign hazard            = issue_bus.valid_i & (rs1_busy | rs2_busy | rd_busy);
  assign drain             = out_valid & (|(out_sel & issue_bus.unit_ready_i));
  assign issue_bus.ready_o = ~hazard & (~out_valid | drain) & ~flush_req;
  assign accept            = issue_bus.valid_i & issue_bus.ready_o;

  // Operand selection: regfile data, optionally overridden by the value
  // being written back this cycle, with x0 forced to zero last.
  always_comb begin
    in_ops.rs1_value = rf_rs1_data;
    in_ops.rs2_value = rf_rs2_data;
`ifdef HSV_CORE_ISSUE_WB_BYPASS_EN
    if (wb_valid && (wb_rd == in_data.common.rs1_addr)) in_ops.rs1_value = wb_data;
    if (wb_valid && (wb_rd == in_data.common.rs2_addr)) in_ops.rs2_value = wb_data;
`endif
    in_ops.rs1_value = zero_x0(in_data.common.rs1_addr, in_ops.rs1_value);
    in_ops.rs2_value = zero_x0(in_data.common.rs2_addr, in_ops.rs2_value);
  end

`ifndef HSV_CORE_ISSUE_WB_BYPASS_EN
  logic [31:0] unused_wb_data;
  assign unused_wb_data = wb_data;
`endif

  // Output entry occupancy and flush acknowledge. Reset beats flush, and
  // flush beats a new accept (accept is already gated off by flush_req).
  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      out_valid <= 1'b0;
      flush_ack <= 1'b1;
    end else begin
      flush_ack <= flush_req;
      if (flush_req)   out_valid <= 1'b0;
      else if (accept) out_valid <= 1'b1;
      else if (drain)  out_valid <= 1'b0;
    end
  end

  // Payload only loads on accept, so it holds stable while a unit stalls.
  always_ff @(posedge clk_core) begin
    if (accept) begin
      out_sel  <= NUM_UNITS'(in_data.exec_select);
      out_data <= in_data;
      out_ops  <= in_ops;
    end
  end

  assign issue_bus.unit_valid_o  = {NUM_UNITS{out_valid}} & out_sel;
  assign issue_bus.dispatch_data = out_data;
  assign issue_bus.rs1_value     = out_ops.rs1_value;
  assign issue_bus.rs2_value     = out_ops.rs2_value;

  // A valid beat must target exactly one execution unit.
  always_ff @(posedge clk_core) begin
    if (rst_core_n && issue_bus.valid_i) begin
      assert ($onehot(in_data.exec_select));
    end
  end

endmodule

// File: tb/tb_hsv_core_issue.sv
// tb_hsv_core_issue
// Self-checking bench for hsv_core_issue: directed scenarios followed by
// randomized beats. A reference model (busy set, register file array and an
// expected-dispatch queue) predicts ready_o, flush_ack and every dispatch;
// a separate monitor compares the unit bus against the queue.
// Honours HSV_CORE_ISSUE_WB_BYPASS_EN to select the matching model rules.
`timescale 1ns/1ps
module tb_hsv_core_issue;
  import hsv_core_issue_pkg::*;

`ifdef HSV_CORE_ISSUE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    issue_data_t data;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  logic        clk_core   = 1'b0;
  logic        rst_core_n = 1'b0;
  logic        flush_req  = 1'b0;
  logic        flush_ack;
  reg_addr_t   rf_rs1_addr;
  reg_addr_t   rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        wb_valid   = 1'b0;
  reg_addr_t   wb_rd      = '0;
  logic [31:0] wb_data    = '0;

  hsv_core_issue_if #(.NUM_UNITS(5)) bus ();

  hsv_core_issue #(
    .NUM_REGS  (32),
    .NUM_UNITS (5)
  ) dut (
    .clk_core    (clk_core),
    .rst_core_n  (rst_core_n),
    .flush_req   (flush_req),
    .flush_ack   (flush_ack),
    .issue_bus   (bus),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  always #5 clk_core = ~clk_core;

  // Bench-owned register file; x0 holds garbage so zeroing is observable
  logic [31:0] tb_rf [32];
  assign rf_rs1_data = tb_rf[rf_rs1_addr];
  assign rf_rs2_data = tb_rf[rf_rs2_addr];

  bit   model_busy [32];
  exp_t exp_q [$];
  logic exp_fa;
  bit   checks_on = 1'b0;
  bit   last_acc;
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit regBlocked(reg_addr_t r, bit wv, reg_addr_t wr);
    return (r != 0) && model_busy[r] && !(BYPASS && wv && (wr == r));
  endfunction

  function automatic logic [31:0] expOperand(reg_addr_t a, bit wv, reg_addr_t wr, logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (BYPASS && wv && (wr == a)) return wd;
    return tb_rf[a];
  endfunction

  function automatic issue_data_t mkBeat(int sel, int rs1, int rs2, int rd, bit illegal);
    issue_data_t d;
    d.common.pc       = $urandom;
    d.common.rs1_addr = 5'(rs1);
    d.common.rs2_addr = 5'(rs2);
    d.common.rd_addr  = 5'(rd);
    d.exec_select     = exec_select_t'(5'(1 << sel));
    d.alu_data.illegal = illegal;
    d.alu_data.op     = 4'($urandom);
    d.imm             = $urandom;
    return d;
  endfunction

  // One clock of stimulus: drive after the edge, then evaluate the model and
  // compare ready_o / flush_ack before the next edge.
  task automatic applyStimulus(input bit v, input issue_data_t d, input logic [4:0] ur,
                               input bit wv, input reg_addr_t wr, input logic [31:0] wd,
                               input bit fl, input bit rn);
    bit blocked;
    bit exp_ready;
    exp_t e;
    @(posedge clk_core);
    #1;
    if (wb_valid && wb_rd != 0) tb_rf[wb_rd] = wb_data;
    bus.valid_i      = v;
    bus.issue_data   = d;
    bus.unit_ready_i = ur;
    wb_valid   = wv;
    wb_rd      = wr;
    wb_data    = wd;
    flush_req  = fl;
    rst_core_n = rn;
    #6;
    blocked = v && (regBlocked(d.common.rs1_addr, wv, wr) || regBlocked(d.common.rs2_addr, wv, wr) ||
                    regBlocked(d.common.rd_addr, wv, wr));
    exp_ready = !blocked && (exp_q.size() == 0) && !fl;
    if (checks_on) checkOutput("flush_ack", flush_ack, exp_fa);
    if (checks_on && rn) checkOutput("ready_o", bus.ready_o, exp_ready);
    last_acc = rn && v && exp_ready;
    if (!rn || fl) begin
      foreach (model_busy[i]) model_busy[i] = 1'b0;
      exp_q.delete();
    end else begin
      if (wv && wr != 0) model_busy[wr] = 1'b0;
      if (last_acc) begin
        e.data = d;
        e.rs1  = expOperand(d.common.rs1_addr, wv, wr, wd);
        e.rs2  = expOperand(d.common.rs2_addr, wv, wr, wd);
        exp_q.push_back(e);
        if (d.common.rd_addr != 0) model_busy[d.common.rd_addr] = 1'b1;
      end
    end
    exp_fa = rn ? fl : 1'b1;
    if (!rn) checks_on = 1'b1;
  endtask

  task automatic idle(input int n, input logic [4:0] ur);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, ur, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic clearBusy();
    for (int r = 1; r < 32; r++)
      if (model_busy[r]) applyStimulus(1'b0, '0, 5'h1f, 1'b1, 5'(r), $urandom, 1'b0, 1'b1);
    idle(2, 5'h1f);
  endtask

  // Present a beat until accepted, with random unit backpressure, flushes and
  // writebacks steered toward busy registers so the beat eventually issues.
  task automatic sendBeat(input issue_data_t d);
    int busy_list [$];
    bit wv;
    reg_addr_t wr;
    for (int n = 0; n < 200; n++) begin
      busy_list.delete();
      for (int r = 1; r < 32; r++) if (model_busy[r]) busy_list.push_back(r);
      wv = ($urandom_range(0, 1) == 1);
      if (busy_list.size() != 0 && $urandom_range(0, 3) != 0)
        wr = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      else
        wr = 5'($urandom_range(0, 7));
      applyStimulus(1'b1, d, 5'($urandom_range(0, 31)), wv, wr, $urandom,
                    ($urandom_range(0, 29) == 0), 1'b1);
      if (last_acc) return;
    end
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL accept_timeout: beat not accepted within 200 cycles");
  endtask

  // Monitor: compares the unit bus against the oldest expected dispatch and
  // retires it when the selected unit is ready.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_core);
      if (checks_on) begin
        if (exp_q.size() == 0) begin
          checkOutput("unit_valid_idle", bus.unit_valid_o, '0);
        end else begin
          e = exp_q[0];
          checkOutput("unit_valid", bus.unit_valid_o, 5'(e.data.exec_select));
          checkOutput("dispatch_data", bus.dispatch_data, e.data);
          checkOutput("rs1_value", bus.rs1_value, e.rs1);
          checkOutput("rs2_value", bus.rs2_value, e.rs2);
          if ((5'(e.data.exec_select) & bus.unit_ready_i) != 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    issue_data_t a;
    issue_data_t b;
    bus.valid_i      = 1'b0;
    bus.issue_data   = '0;
    bus.unit_ready_i = 5'h1f;
    tb_rf[0] = 32'hFFFF_FFFF;
    for (int r = 1; r < 32; r++) tb_rf[r] = $urandom;
    foreach (model_busy[i]) model_busy[i] = 1'b0;

    // Reset
    applyStimulus(1'b0, '0, 5'h1f, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 5'h1f, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(2, 5'h1f);

    // Independent ALU ops back-to-back
    a = mkBeat(UNIT_ALU, 1, 2, 5, 1'b0);
    b = mkBeat(UNIT_ALU, 3, 4, 6, 1'b0);
    applyStimulus(1'b1, a, 5'h1f, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, b, 5'h1f, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(2, 5'h1f);
    clearBusy();

    // RAW on x7 with writeback held off for 3 cycles
    a = mkBeat(UNIT_ALU, 0, 0, 7, 1'b0);
    b = mkBeat(UNIT_ALU, 7, 0, 8, 1'b0);
    applyStimulus(1'b1, a, 5'h1f, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, b, 5'h1f, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, b, 5'h1f, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b1);
    if (!last_acc) applyStimulus(1'b1, b, 5'h1f, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(2, 5'h1f);
    clearBusy();

    // Backpressure on the mem lane
    a = mkBeat(UNIT_MEM, 1, 2, 10, 1'b0);
    b = mkBeat(UNIT_ALU, 3, 4, 11, 1'b0);
    applyStimulus(1'b1, a, 5'h1f, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, b, 5'b11011, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, b, 5'h1f, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(2, 5'h1f);
    clearBusy();

    // x0 destination then x0 source
    a = mkBeat(UNIT_ALU, 1, 2, 0, 1'b0);
    b = mkBeat(UNIT_ALU, 0, 0, 12, 1'b0);
    applyStimulus(1'b1, a, 5'h1f, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, b, 5'h1f, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(2, 5'h1f);
    clearBusy();

    // Flush with a held entry and x9 busy, then read x9
    a = mkBeat(UNIT_MEM, 0, 0, 9, 1'b0);
    b = mkBeat(UNIT_ALU, 9, 0, 13, 1'b0);
    applyStimulus(1'b1, a, 5'h00, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 5'h00, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 5'h00, 1'b0, '0, '0, 1'b1, 1'b1);
    applyStimulus(1'b1, b, 5'h1f, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(2, 5'h1f);
    clearBusy();

    // Illegal instruction on the alu lane, then reset while it is held
    a = mkBeat(UNIT_ALU, 1, 2, 14, 1'b1);
    applyStimulus(1'b1, a, 5'h00, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 5'h00, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 5'h00, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(3, 5'h1f);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = $urandom_range(0, 4);
      a = mkBeat(sel, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 (sel == UNIT_ALU) && ($urandom_range(0, 7) == 0));
      sendBeat(a);
      if ($urandom_range(0, 3) == 0) idle(1, 5'($urandom_range(0, 31)));
    end
    idle(4, 5'h1f);
    checkOutput("queue_drained", 128'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
